// File: rtl/lcd_hd44780_writer.sv
// lcd_hd44780_writer: single-byte HD44780 writer (8-bit or 4-bit bus) with ready/start handshake
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   start          transfer request, sampled only while ready=1
//   data, cd       byte and command(0)/character(1) flag, captured on the accepting edge
//   ready          high exactly while idle
//   lcd_data       LCD data pins (4-bit mode: bits 3..0 drive DB7..DB4)
//   rs, rw, en     LCD register select, read/write (always write), enable strobe
//   done_tick      one-cycle pulse when the transfer completes
module lcd_hd44780_writer #(
    parameter int BUS_WIDTH   = 8,
    parameter int EN_CYCLES   = 50000,
    parameter int HOLD_CYCLES = 25000,
    parameter int LONG_CYCLES = 100000,
    parameter int CNT_W       = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           data,
    input  logic                 cd,
    output logic                 ready,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic                 rs,
    output logic                 rw,
    output logic                 en,
    output logic                 done_tick
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] EN_HI = 3'd2;
    localparam logic [2:0] EN_LO = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [CNT_W-1:0] EN_T   = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(HOLD_CYCLES + LONG_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           byte_q, byte_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 rs_q, rs_d, en_q, en_d, nib_q, nib_d;
    logic [BUS_WIDTH-1:0] hi_w, lo_w;
    logic                 last_w, slow_w;
    logic [CNT_W-1:0]     hold_t_w;

    // First bus value is the whole byte (8-bit) or the high nibble (4-bit)
    assign hi_w = BUS_WIDTH'(BUS_WIDTH == 8 ? data : {4'h0, data[7:4]});
    assign lo_w = BUS_WIDTH'(byte_q[3:0]);
    // The last bus transfer is the only one that may carry the long clear/home wait
    assign last_w   = (BUS_WIDTH == 4) ? nib_q : 1'b1;
    assign slow_w   = last_w && !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
    assign hold_t_w = slow_w ? LONG_T : HOLD_T;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        byte_d  = byte_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        nib_d   = nib_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    byte_d  = data;
                    rs_d    = cd;
                    data_d  = hi_w;
                    nib_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = EN_HI;
            end
            EN_HI: begin
                if (cnt_q == EN_T) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = EN_LO;
                end
            end
            EN_LO: begin
                if (cnt_q == hold_t_w) begin
                    cnt_d   = '0;
                    state_d = last_w ? DONE : SETUP;
                    data_d  = last_w ? data_q : lo_w;
                    nib_d   = 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            nib_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            nib_q   <= nib_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = (state_q == DONE);
    assign lcd_data  = data_q;
    assign rs        = rs_q;
    assign rw        = 1'b0;
    assign en        = en_q;
endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// tb_lcd_hd44780_writer: checks 8-bit, 4-bit and default-parameter writers against a timeline model
module tb_lcd_hd44780_writer;
    logic       clk, rst, start, cd;
    logic [7:0] data;
    int         sel;
    int         vectors, miscompares, dones;

    logic       ready8, rs8, rw8, en8, done8;
    logic [7:0] lcd8;
    logic       ready4, rs4, rw4, en4, done4;
    logic [3:0] lcd4;
    logic       readyd, rsd, rwd, end_, doned;
    logic [7:0] lcdd;
    logic [12:0] obs;

    lcd_hd44780_writer #(.BUS_WIDTH(8), .EN_CYCLES(4), .HOLD_CYCLES(2), .LONG_CYCLES(10), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .data(data), .cd(cd),
        .ready(ready8), .lcd_data(lcd8), .rs(rs8), .rw(rw8), .en(en8), .done_tick(done8));

    lcd_hd44780_writer #(.BUS_WIDTH(4), .EN_CYCLES(4), .HOLD_CYCLES(2), .LONG_CYCLES(10), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .data(data), .cd(cd),
        .ready(ready4), .lcd_data(lcd4), .rs(rs4), .rw(rw4), .en(en4), .done_tick(done4));

    lcd_hd44780_writer dutd (
        .clk(clk), .rst(rst), .start(start && sel == 2), .data(data), .cd(cd),
        .ready(readyd), .lcd_data(lcdd), .rs(rsd), .rw(rwd), .en(end_), .done_tick(doned));

    // Observed pins of the selected instance: {rw, ready, done_tick, en, rs, lcd_data}
    always_comb
        obs = sel == 0 ? {rw8, ready8, done8, en8, rs8, lcd8} :
              sel == 1 ? {rw4, ready4, done4, en4, rs4, 4'h0, lcd4} :
                         {rwd, readyd, doned, end_, rsd, lcdd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done8) dones++;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, o, e, $time);
        end
    endtask

    task automatic wiggle(input bit keep, input logic [7:0] nd, input logic c);
        if (keep) begin
            start = 1'b1;
            data  = nd;
            cd    = c;
        end else begin
            start = 1'($urandom % 2);
            data  = 8'($urandom);
            cd    = 1'($urandom % 2);
        end
    endtask

    // Timeline model: per bus transfer, 1 setup cycle, EN cycles of en high, then the hold
    // (stretched by LONG on the final transfer of a clear/home command), then one done cycle.
    task automatic xfer(input int s, input logic [7:0] d, input logic c, input bit keep, input logic [7:0] nd);
        int en_c, hold_c, long_c, nn, len;
        bit slow;
        logic [7:0] v;
        en_c   = s == 2 ? 50000 : 4;
        hold_c = s == 2 ? 25000 : 2;
        long_c = s == 2 ? 100000 : 10;
        nn     = s == 1 ? 2 : 1;
        slow   = !c && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        v      = d;
        sel    = s;
        data   = d;
        cd     = c;
        start  = 1'b1;
        @(posedge clk);
        for (int n = 0; n < nn; n++) begin
            v   = s == 1 ? (n == 0 ? {4'h0, d[7:4]} : {4'h0, d[3:0]}) : d;
            len = 1 + en_c + hold_c + ((slow && n == nn - 1) ? long_c : 0);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                check("busy", obs, {1'b0, 1'b0, 1'b0, (k >= 1 && k <= en_c), c, v});
                wiggle(keep, nd, c);
            end
        end
        @(negedge clk);
        check("done", obs, {1'b0, 1'b0, 1'b1, 1'b0, c, v});
        wiggle(keep, nd, c);
        @(negedge clk);
        check("ready", obs, {1'b0, 1'b1, 1'b0, 1'b0, c, v});
        if (!keep) start = 1'b0;
    endtask

    initial begin
        int d0;
        logic [7:0] rd;
        logic rc;
        vectors = 0;
        miscompares = 0;
        dones = 0;
        rst = 1'b0;
        start = 1'b0;
        data = 8'h00;
        cd = 1'b0;
        sel = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check("reset", obs, 13'h1000 >> 1);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle", obs, 13'h0800);

        xfer(0, 8'h41, 1'b1, 1'b0, 8'h00);
        xfer(1, 8'hA5, 1'b0, 1'b0, 8'h00);
        xfer(0, 8'h01, 1'b0, 1'b0, 8'h00);
        xfer(0, 8'h01, 1'b1, 1'b0, 8'h00);
        xfer(1, 8'h01, 1'b0, 1'b0, 8'h00);
        xfer(1, 8'h03, 1'b0, 1'b0, 8'h00);
        xfer(0, 8'h04, 1'b0, 1'b0, 8'h00);

        d0 = dones;
        xfer(0, 8'h30, 1'b0, 1'b1, 8'h38);
        xfer(0, 8'h38, 1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        check("two_dones", 32'(dones - d0), 32'd2);

        sel = 0;
        data = 8'h55;
        cd = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("in_en_hi", obs, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55});
        #2 rst = 1'b0;
        #1 check("async_rst", obs, 13'h0800);
        d0 = dones;
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst", obs, 13'h0800);
        end
        check("no_done", 32'(dones - d0), 32'd0);
        xfer(0, 8'h02, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom);
            rc = 1'($urandom % 2);
            if ($urandom % 3 == 0) begin
                rd = 8'(1 + $urandom % 3);
                rc = 1'b0;
            end
            xfer(int'($urandom % 2), rd, rc, 1'b0, 8'h00);
        end

        xfer(2, 8'h48, 1'b1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
